// File: rtl/ctrl_cnt_ac2_prog.sv
// Programmable AC2 sample counter: counts ac2_cnt strobes up to a selectable terminal value,
// repeats that window n_pass times and flags each window end and the end of the run.
//
// state | meaning
// IDLE  | waiting for start; ac2_cnt ignored; config checked on start
// RUN   | counting strobes against the latched limit and pass count
// DONE  | one-cycle completion state; pass_val holds the final count
module ctrl_cnt_ac2_prog #(
    parameter int Pw      = 8,
    parameter int NPASS_W = 4,
    localparam int CW     = $clog2(Pw) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cnt_clear,
    input  logic               start,
    input  logic               ac2_cnt,
    input  logic [1:0]         par_sel_Pw,
    input  logic [CW-1:0]      len_custom,
    input  logic [NPASS_W-1:0] n_pass,
    output logic               term_ac2,
    output logic               done,
    output logic               busy,
    output logic               cfg_err,
    output logic [CW-1:0]      cnt_val,
    output logic [NPASS_W-1:0] pass_val
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt_nxt;
    logic [NPASS_W-1:0]   pass_nxt;
    logic [CW-1:0]        limit_q, limit_nxt;
    logic [NPASS_W-1:0]   npass_q, npass_nxt;
    logic                 term_nxt, done_nxt, err_nxt;
    logic [CW-1:0]        limit_sel;
    logic                 cfg_bad;
    logic [NPASS_W-1:0]   pass_inc;

    always_comb begin
        limit_sel = len_custom;
        case (par_sel_Pw)
            2'b00:   limit_sel = CW'(Pw / 2);
            2'b01:   limit_sel = CW'(Pw - 2);
            2'b10:   limit_sel = CW'(Pw);
            default: limit_sel = len_custom;
        endcase
    end

    assign cfg_bad  = (limit_sel == '0) || (limit_sel > CW'(Pw)) || (n_pass == '0);
    assign pass_inc = pass_val + 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_val;
        pass_nxt  = pass_val;
        limit_nxt = limit_q;
        npass_nxt = npass_q;
        term_nxt  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        cnt_nxt   = CW'(1);
                        pass_nxt  = '0;
                        limit_nxt = limit_sel;
                        npass_nxt = n_pass;
                    end
                end
            end
            RUN: begin
                if (ac2_cnt) begin
                    if (cnt_val == limit_q) begin
                        cnt_nxt  = CW'(1);
                        pass_nxt = pass_inc;
                        term_nxt = 1'b1;
                        if (pass_inc == npass_q) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt_val + 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clear behaves exactly like reset, so an aborted window never reports term/done.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clear) begin
            state    <= IDLE;
            cnt_val  <= CW'(1);
            pass_val <= '0;
            limit_q  <= '0;
            npass_q  <= '0;
            term_ac2 <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt_val  <= cnt_nxt;
            pass_val <= pass_nxt;
            limit_q  <= limit_nxt;
            npass_q  <= npass_nxt;
            term_ac2 <= term_nxt;
            done     <= done_nxt;
            cfg_err  <= err_nxt;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_ctrl_cnt_ac2_prog.sv
// Directed self-checking bench for ctrl_cnt_ac2_prog (Pw=8, NPASS_W=4).
module tb_ctrl_cnt_ac2_prog;

    logic       clk = 1'b0;
    logic       rst_n, cnt_clear, start, ac2_cnt;
    logic [1:0] par_sel_Pw;
    logic [3:0] len_custom, n_pass;
    logic       term_ac2, done, busy, cfg_err;
    logic [3:0] cnt_val, pass_val;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    ctrl_cnt_ac2_prog #(.Pw(8), .NPASS_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_clear(cnt_clear), .start(start), .ac2_cnt(ac2_cnt),
        .par_sel_Pw(par_sel_Pw), .len_custom(len_custom), .n_pass(n_pass),
        .term_ac2(term_ac2), .done(done), .busy(busy), .cfg_err(cfg_err),
        .cnt_val(cnt_val), .pass_val(pass_val)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        ac2_cnt = 1'b1;
        tick();
        ac2_cnt = 1'b0;
    endtask

    task automatic kick(input logic [1:0] sel, input logic [3:0] len, input logic [3:0] np);
        par_sel_Pw = sel;
        len_custom = len;
        n_pass     = np;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // flags = {term_ac2, done, busy, cfg_err}
    task automatic test_reset();
        rst_n = 1'b0; cnt_clear = 1'b0; start = 1'b1; ac2_cnt = 1'b1;
        par_sel_Pw = 2'b10; len_custom = 4'd0; n_pass = 4'd1;
        tick(); tick();
        chk_cnt++;
        if ({term_ac2, done, busy, cfg_err, cnt_val, pass_val} !== {4'b0000, 4'd1, 4'd0})
            $display("FAIL reset actual=%b required=%b",
                     {term_ac2, done, busy, cfg_err, cnt_val, pass_val}, {4'b0000, 4'd1, 4'd0});
        else pass_cnt++;
        rst_n = 1'b1; start = 1'b0; ac2_cnt = 1'b0;
        // ac2_cnt is ignored while idle
        strobe();
        chk_cnt++;
        if ({busy, term_ac2, cnt_val} !== {2'b00, 4'd1})
            $display("FAIL idle_ignore actual=%b required=%b", {busy, term_ac2, cnt_val}, {2'b00, 4'd1});
        else pass_cnt++;
    endtask

    task automatic test_full_window();
        kick(2'b10, 4'd0, 4'd1);
        chk_cnt++;
        if ({busy, cnt_val, pass_val} !== {1'b1, 4'd1, 4'd0})
            $display("FAIL t1_start actual=%b required=%b", {busy, cnt_val, pass_val}, {1'b1, 4'd1, 4'd0});
        else pass_cnt++;
        for (int i = 1; i <= 7; i++) begin
            strobe();
            chk_cnt++;
            if ({term_ac2, done, busy, cnt_val} !== {3'b001, 4'(i + 1)})
                $display("FAIL t1_count%0d actual=%b required=%b", i,
                         {term_ac2, done, busy, cnt_val}, {3'b001, 4'(i + 1)});
            else pass_cnt++;
        end
        strobe();
        chk_cnt++;
        if ({term_ac2, done, busy, cnt_val, pass_val} !== {3'b110, 4'd1, 4'd1})
            $display("FAIL t1_term actual=%b required=%b",
                     {term_ac2, done, busy, cnt_val, pass_val}, {3'b110, 4'd1, 4'd1});
        else pass_cnt++;
        // start during DONE must not relaunch
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cnt++;
        if ({term_ac2, done, busy, pass_val} !== {3'b000, 4'd1})
            $display("FAIL t1_after_done actual=%b required=%b", {term_ac2, done, busy, pass_val}, {3'b000, 4'd1});
        else pass_cnt++;
    endtask

    task automatic test_multi_pass();
        kick(2'b00, 4'd0, 4'd3);
        for (int i = 1; i <= 12; i++) begin
            strobe();
            chk_cnt++;
            if ({term_ac2, done, busy, pass_val} !== {(i % 4 == 0), (i == 12), (i != 12), 4'(i / 4)})
                $display("FAIL t2_strobe%0d actual=%b required=%b", i, {term_ac2, done, busy, pass_val},
                         {(i % 4 == 0), (i == 12), (i != 12), 4'(i / 4)});
            else pass_cnt++;
            tick();
            chk_cnt++;
            if ({term_ac2, done} !== 2'b00)
                $display("FAIL t2_gap%0d actual=%b required=00", i, {term_ac2, done});
            else pass_cnt++;
        end
        chk_cnt++;
        if ({busy, pass_val} !== {1'b0, 4'd3})
            $display("FAIL t2_final actual=%b required=%b", {busy, pass_val}, {1'b0, 4'd3});
        else pass_cnt++;
    endtask

    task automatic test_limits();
        logic [1:0] sels [2] = '{2'b01, 2'b11};
        int         lims [2] = '{6, 5};
        for (int k = 0; k < 2; k++) begin
            kick(sels[k], 4'd5, 4'd1);
            for (int i = 1; i <= lims[k]; i++) begin
                strobe();
                chk_cnt++;
                if ({term_ac2, done} !== {2{i == lims[k]}})
                    $display("FAIL t3_lim%0d_strobe%0d actual=%b required=%b", lims[k], i,
                             {term_ac2, done}, {2{i == lims[k]}});
                else pass_cnt++;
            end
            tick();
        end
        // limit 1 with back-to-back strobes: term_ac2 stays high every cycle
        kick(2'b11, 4'd1, 4'd3);
        ac2_cnt = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_cnt++;
            if ({term_ac2, done, cnt_val, pass_val} !== {1'b1, (i == 3), 4'd1, 4'(i)})
                $display("FAIL t3_len1_%0d actual=%b required=%b", i,
                         {term_ac2, done, cnt_val, pass_val}, {1'b1, (i == 3), 4'd1, 4'(i)});
            else pass_cnt++;
        end
        ac2_cnt = 1'b0;
        tick();
    endtask

    task automatic test_cfg_err();
        logic [1:0] sels [4] = '{2'b11, 2'b11, 2'b10, 2'b11};
        logic [3:0] lens [4] = '{4'd0, 4'd9, 4'd0, 4'd8};
        logic [3:0] nps  [4] = '{4'd1, 4'd1, 4'd0, 4'd1};
        for (int k = 0; k < 4; k++) begin
            kick(sels[k], lens[k], nps[k]);
            chk_cnt++;
            if ({cfg_err, busy} !== {(k != 3), (k == 3)})
                $display("FAIL t4_case%0d actual=%b required=%b", k, {cfg_err, busy}, {(k != 3), (k == 3)});
            else pass_cnt++;
            if (k == 3) begin
                cnt_clear = 1'b1;
                tick();
                cnt_clear = 1'b0;
            end else begin
                tick();
                chk_cnt++;
                if ({cfg_err, busy} !== 2'b00)
                    $display("FAIL t4_pulse%0d actual=%b required=00", k, {cfg_err, busy});
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_clear();
        kick(2'b00, 4'd0, 4'd1);
        strobe(); strobe(); strobe();
        chk_cnt++;
        if (cnt_val !== 4'd4)
            $display("FAIL t5_pre actual=%0d required=4", cnt_val);
        else pass_cnt++;
        ac2_cnt = 1'b1; cnt_clear = 1'b1;
        tick();
        ac2_cnt = 1'b0; cnt_clear = 1'b0;
        chk_cnt++;
        if ({term_ac2, done, busy, cfg_err, cnt_val, pass_val} !== {4'b0000, 4'd1, 4'd0})
            $display("FAIL t5_clear actual=%b required=%b",
                     {term_ac2, done, busy, cfg_err, cnt_val, pass_val}, {4'b0000, 4'd1, 4'd0});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({term_ac2, done, busy} !== 3'b000)
            $display("FAIL t5_post actual=%b required=000", {term_ac2, done, busy});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        kick(2'b00, 4'd0, 4'd2);
        strobe(); strobe();
        // changing config and pulsing start mid-run must not disturb the latched limit
        par_sel_Pw = 2'b10; start = 1'b1;
        strobe(); strobe();
        start = 1'b0;
        chk_cnt++;
        if ({term_ac2, done, busy, pass_val} !== {3'b101, 4'd1})
            $display("FAIL t6_win1 actual=%b required=%b", {term_ac2, done, busy, pass_val}, {3'b101, 4'd1});
        else pass_cnt++;
        for (int i = 1; i <= 4; i++) strobe();
        chk_cnt++;
        if ({term_ac2, done, busy, pass_val} !== {3'b110, 4'd2})
            $display("FAIL t6_win2 actual=%b required=%b", {term_ac2, done, busy, pass_val}, {3'b110, 4'd2});
        else pass_cnt++;
        tick();
        kick(2'b10, 4'd0, 4'd1);
        strobe(); strobe();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_cnt++;
        if ({term_ac2, done, busy, cfg_err, cnt_val, pass_val} !== {4'b0000, 4'd1, 4'd0})
            $display("FAIL t6_reset actual=%b required=%b",
                     {term_ac2, done, busy, cfg_err, cnt_val, pass_val}, {4'b0000, 4'd1, 4'd0});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_multi_pass();
        test_limits();
        test_cfg_err();
        test_clear();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
